// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - writeback register-file port arbiter between pipeline and mul/div unit
// Pipeline writes always win; a mul/div result waits in a one-entry buffer and forces a stall once starved.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] MemoryData,
  input  logic [31:0] ALUResult,
  input  logic [4:0]  RegWriteAdd,
  input  logic        MD_Valid,
  input  logic [31:0] MD_Data,
  input  logic [4:0]  MD_WriteAdd,
  output logic        MD_Ready,
  output logic        RF_WE,
  output logic [4:0]  RF_WriteAdd,
  output logic [31:0] RF_WriteData,
  output logic        Pipe_Stall
);

  typedef enum logic [1:0] {IDLE, HELD, STARVED} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, stateNext;
  logic [4:0]  bufAdd, bufAddNext;
  logic [31:0] bufData, bufDataNext;
  logic [3:0]  waitCnt, waitCntNext;

  logic bufValid, slotActive, accept, keep;

  assign bufValid   = (state != IDLE);
  assign slotActive = RegWrite && (RegWriteAdd != 5'd0);
  assign MD_Ready   = !rst && !bufValid;
  assign Pipe_Stall = !rst && (state == STARVED);
  assign accept     = MD_Valid && MD_Ready;
  // A result aimed at r0 or at the register the pipeline writes this cycle is already stale.
  assign keep       = accept && (MD_WriteAdd != 5'd0) &&
                      !(slotActive && (MD_WriteAdd == RegWriteAdd));

  always_comb begin
    RF_WE        = 1'b0;
    RF_WriteAdd  = 5'd0;
    RF_WriteData = 32'd0;
    if (!rst) begin
      if (slotActive) begin
        RF_WE        = 1'b1;
        RF_WriteAdd  = RegWriteAdd;
        RF_WriteData = MemtoReg ? MemoryData : ALUResult;
      end else if (bufValid && (bufAdd != 5'd0)) begin
        RF_WE        = 1'b1;
        RF_WriteAdd  = bufAdd;
        RF_WriteData = bufData;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    bufAddNext  = bufAdd;
    bufDataNext = bufData;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        if (keep) begin
          stateNext   = HELD;
          bufAddNext  = MD_WriteAdd;
          bufDataNext = MD_Data;
          waitCntNext = 4'd0;
        end
      end
      HELD, STARVED: begin
        // Either the port was free (drain) or the pipeline overwrote the same register (supersede).
        if (!slotActive || (RegWriteAdd == bufAdd)) begin
          stateNext   = IDLE;
          bufAddNext  = 5'd0;
          bufDataNext = 32'd0;
          waitCntNext = 4'd0;
        end else if (state == HELD) begin
          waitCntNext = waitCnt + 4'd1;
          if (waitCnt + 4'd1 >= LIMIT) begin
            stateNext = STARVED;
          end
        end
      end
      default: begin
        stateNext   = IDLE;
        bufAddNext  = 5'd0;
        bufDataNext = 32'd0;
        waitCntNext = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bufAdd  <= 5'd0;
      bufData <= 32'd0;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      bufAdd  <= bufAddNext;
      bufData <= bufDataNext;
      waitCnt <= waitCntNext;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed bench for wb_port_arbiter
// Expected register-file writes are queued as stimulus is driven and popped when the DUT writes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg;
  logic [31:0] MemoryData, ALUResult;
  logic [4:0]  RegWriteAdd;
  logic        MD_Valid;
  logic [31:0] MD_Data;
  logic [4:0]  MD_WriteAdd;
  logic        MD_Ready, RF_WE, Pipe_Stall;
  logic [4:0]  RF_WriteAdd;
  logic [31:0] RF_WriteData;

  typedef struct packed {
    logic [4:0]  add;
    logic [31:0] data;
  } wr_t;

  wr_t expq[$];
  int  checks   = 0;
  int  failures = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemoryData(MemoryData),
    .ALUResult(ALUResult), .RegWriteAdd(RegWriteAdd),
    .MD_Valid(MD_Valid), .MD_Data(MD_Data), .MD_WriteAdd(MD_WriteAdd),
    .MD_Ready(MD_Ready), .RF_WE(RF_WE), .RF_WriteAdd(RF_WriteAdd),
    .RF_WriteData(RF_WriteData), .Pipe_Stall(Pipe_Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RegWrite = 1'b0; MemtoReg = 1'b0; MemoryData = 32'd0; ALUResult = 32'd0;
    RegWriteAdd = 5'd0; MD_Valid = 1'b0; MD_Data = 32'd0; MD_WriteAdd = 5'd0;
  endtask

  task automatic slot(input logic [4:0] a, input logic m2r, input logic [31:0] mem, input logic [31:0] alu);
    RegWrite = 1'b1; RegWriteAdd = a; MemtoReg = m2r; MemoryData = mem; ALUResult = alu;
    expq.push_back({a, m2r ? mem : alu});
  endtask

  task automatic md(input logic [4:0] a, input logic [31:0] d);
    MD_Valid = 1'b1; MD_WriteAdd = a; MD_Data = d;
  endtask

  // Sample away from the rising edge and retire any write against the scoreboard.
  task automatic settle();
    wr_t e;
    @(negedge clk);
    if (RF_WE === 1'b1) begin
      chk("sb_write_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("sb_add", 32'(RF_WriteAdd), 32'(e.add));
        chk("sb_data", RF_WriteData, e.data);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;

  initial begin
    rst = 1'b1;
    idle();
    RegWrite = 1'b1; RegWriteAdd = 5'd5; MD_Valid = 1'b1; MD_WriteAdd = 5'd2;
    @(negedge clk);
    chk("rst_rf_we", 32'(RF_WE), 32'd0);
    chk("rst_rf_add", 32'(RF_WriteAdd), 32'd0);
    chk("rst_rf_data", RF_WriteData, 32'd0);
    chk("rst_md_ready", 32'(MD_Ready), 32'd0);
    chk("rst_stall", 32'(Pipe_Stall), 32'd0);
    advance();
    rst = 1'b0;
    idle();
    settle();
    chk("post_rst_md_ready", 32'(MD_Ready), 32'd1);
    chk("post_rst_stall", 32'(Pipe_Stall), 32'd0);
    chk("post_rst_rf_we", 32'(RF_WE), 32'd0);
    advance();

    // Pipeline write, both source selects
    slot(5'd5, 1'b1, 32'hDEADBEEF, 32'h1);
    settle();
    chk("slot_mem_we", 32'(RF_WE), 32'd1);
    advance();
    slot(5'd6, 1'b0, 32'hDEADBEEF, 32'h0BAD_F00D);
    settle();
    advance();

    // Accepted result written from buffer next cycle
    idle();
    md(5'd9, 32'h1234);
    settle();
    chk("acc_md_ready", 32'(MD_Ready), 32'd1);
    chk("acc_no_bypass", 32'(RF_WE), 32'd0);
    advance();
    idle();
    expq.push_back({5'd9, 32'h1234});
    settle();
    chk("drain_md_ready", 32'(MD_Ready), 32'd0);
    chk("drain_we", 32'(RF_WE), 32'd1);
    advance();
    settle();
    chk("after_drain_md_ready", 32'(MD_Ready), 32'd1);
    chk("after_drain_we", 32'(RF_WE), 32'd0);
    advance();

    // Starvation: four blocked cycles, stall, then bubble drains
    d = $urandom;
    md(5'd9, d);
    settle();
    advance();
    idle();
    for (int i = 0; i < 4; i++) begin
      slot(5'd3, 1'b0, 32'h0, 32'h300 + 32'(i));
      settle();
      chk("held_no_stall", 32'(Pipe_Stall), 32'd0);
      chk("held_md_ready", 32'(MD_Ready), 32'd0);
      advance();
    end
    slot(5'd3, 1'b1, 32'h3333, 32'h0);
    settle();
    chk("starved_stall", 32'(Pipe_Stall), 32'd1);
    advance();
    idle();
    expq.push_back({5'd9, d});
    settle();
    chk("bubble_stall", 32'(Pipe_Stall), 32'd1);
    chk("bubble_we", 32'(RF_WE), 32'd1);
    advance();
    settle();
    chk("after_bubble_stall", 32'(Pipe_Stall), 32'd0);
    chk("after_bubble_md_ready", 32'(MD_Ready), 32'd1);
    advance();

    // Supersede of a buffered result
    md(5'd7, 32'h7777);
    settle();
    advance();
    idle();
    slot(5'd7, 1'b0, 32'h0, 32'h5555);
    settle();
    advance();
    idle();
    settle();
    chk("sup_no_write", 32'(RF_WE), 32'd0);
    chk("sup_md_ready", 32'(MD_Ready), 32'd1);
    advance();

    // Same-cycle supersede of an incoming result
    slot(5'd12, 1'b1, 32'hC0C0, 32'h0);
    md(5'd12, 32'h1212);
    settle();
    advance();
    idle();
    settle();
    chk("same_sup_no_write", 32'(RF_WE), 32'd0);
    chk("same_sup_md_ready", 32'(MD_Ready), 32'd1);
    advance();

    // r0 targets are never written
    md(5'd0, 32'hFFFF);
    settle();
    advance();
    idle();
    settle();
    chk("r0_md_ready", 32'(MD_Ready), 32'd1);
    chk("r0_md_no_write", 32'(RF_WE), 32'd0);
    advance();
    RegWrite = 1'b1; RegWriteAdd = 5'd0; ALUResult = 32'hABCD;
    settle();
    chk("r0_slot_we", 32'(RF_WE), 32'd0);
    chk("r0_slot_add", 32'(RF_WriteAdd), 32'd0);
    advance();

    // Reset while starved loses the buffered result
    idle();
    md(5'd10, 32'hA0A0);
    settle();
    advance();
    idle();
    for (int i = 0; i < 4; i++) begin
      slot(5'd4, 1'b0, 32'h0, 32'h400 + 32'(i));
      settle();
      advance();
    end
    slot(5'd4, 1'b0, 32'h0, 32'h444);
    settle();
    chk("pre_rst_stall", 32'(Pipe_Stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(RF_WE), 32'd0);
    chk("mid_rst_add", 32'(RF_WriteAdd), 32'd0);
    chk("mid_rst_data", RF_WriteData, 32'd0);
    chk("mid_rst_stall", 32'(Pipe_Stall), 32'd0);
    chk("mid_rst_md_ready", 32'(MD_Ready), 32'd0);
    advance();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lost_buf_no_write", 32'(RF_WE), 32'd0);
      chk("lost_buf_md_ready", 32'(MD_Ready), 32'd1);
      advance();
    end

    chk("sb_all_retired", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
